// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared CPU fetch constants and fetch state encoding
// Purpose: default widths, the HALT encoding and the fetch FSM states, shared by
//          fetch and decode.
// Ports:   none (package).
package fetch_unit_pkg;

  localparam int              CPU_ADDR_W    = 4;
  localparam int              CPU_INSTR_W   = 8;
  localparam logic [7:0]      CPU_HALT_WORD = 8'h00;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with load, increment and hold
// Purpose: holds the fetch PC; load wins over increment, increment wraps modulo
//          2**ADDR_W, otherwise the value is held.
// Ports:   clk, rst (sync active-high), load/load_val (redirect target),
//          inc (advance by one), pc (current value).
module fetch_pc_reg #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;  // natural overflow gives the 15 -> 0 wrap
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, instruction register, handshake, halt
// Purpose: drives the ROM address from the PC, captures the returned word into the
//          instruction register and offers it to decode over valid/ready. Execute
//          redirects override everything except reset; fetching HALT_WORD parks the
//          stage until the next redirect.
// Ports:   clk, rst (sync active-high); imem_addr/imem_data (combinational ROM);
//          instr/instr_pc/instr_valid/instr_ready (to decode);
//          redirect_valid/redirect_pc (from execute); halted (status).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = CPU_ADDR_W,
  parameter int                INSTR_W   = CPU_INSTR_W,
  parameter bit                HALT_EN   = 1'b1,
  parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(CPU_HALT_WORD)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              load;
  logic              transfer;
  logic              is_halt;
  logic              pc_inc;

  // The IR can take a new word when it is empty or being drained this cycle.
  assign load     = !instr_valid || instr_ready;
  assign transfer = instr_valid && instr_ready;
  assign is_halt  = HALT_EN && (imem_data == HALT_WORD);

  // A captured halt word keeps the PC pointing at itself.
  assign pc_inc   = !redirect_valid && (state == FETCH_RUN) && load && !is_halt;

  assign imem_addr = pc;

  fetch_pc_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (redirect_valid),
    .load_val (redirect_pc),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_RUN;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect_valid) begin
      // Flush the IR even if decode is taking it: that word is on the wrong path.
      state       <= FETCH_RUN;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        FETCH_HALT: begin
          if (transfer) instr_valid <= 1'b0;
        end
        default: begin
          if (load) begin
            instr       <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            if (is_halt) begin
              state  <= FETCH_HALT;
              halted <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
// Purpose: directed vector table and hand sequences for the halt/stall/redirect/wrap
//          cases, then randomized ready/redirect/reset traffic against a
//          behavioural model of the fetch stage.
// Ports:   none (top-level bench).
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rom [16];

  // DUT 0: default parameters (halt detection on)
  logic       rst, rdy, rv;
  logic [3:0] rpc;
  logic [3:0] addr0, ipc0;
  logic [7:0] ins0;
  logic       v0, h0;
  logic [7:0] data0;
  assign data0 = rom[addr0];

  fetch_unit u0 (
    .clk(clk), .rst(rst), .imem_addr(addr0), .imem_data(data0),
    .instr(ins0), .instr_pc(ipc0), .instr_valid(v0), .instr_ready(rdy),
    .redirect_valid(rv), .redirect_pc(rpc), .halted(h0)
  );

  // DUT 1: halt detection disabled
  logic       rst1, rdy1, rv1;
  logic [3:0] rpc1;
  logic [3:0] addr1, ipc1;
  logic [7:0] ins1;
  logic       v1, h1;
  logic [7:0] data1;
  assign data1 = rom[addr1];

  fetch_unit #(.HALT_EN(1'b0)) u1 (
    .clk(clk), .rst(rst1), .imem_addr(addr1), .imem_data(data1),
    .instr(ins1), .instr_pc(ipc1), .instr_valid(v1), .instr_ready(rdy1),
    .redirect_valid(rv1), .redirect_pc(rpc1), .halted(h1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         rst, rdy, rv;
    logic [3:0] rpc;
    bit         v;
    logic [7:0] ins;
    logic [3:0] ipc, addr;
    bit         h;
  } vec_t;

  function automatic vec_t mk(bit r, bit y, bit w, logic [3:0] t, bit v,
                              logic [7:0] i, logic [3:0] p, logic [3:0] a, bit h);
    vec_t x;
    x.rst = r; x.rdy = y; x.rv = w; x.rpc = t;
    x.v = v; x.ins = i; x.ipc = p; x.addr = a; x.h = h;
    return x;
  endfunction

  vec_t vec [25];

  task automatic cmp0(input string tag, input bit v, input logic [7:0] i,
                      input logic [3:0] p, input logic [3:0] a, input bit h);
    check({tag, ".valid"},  int'(v0),    int'(v));
    check({tag, ".instr"},  int'(ins0),  int'(i));
    check({tag, ".pc"},     int'(ipc0),  int'(p));
    check({tag, ".addr"},   int'(addr0), int'(a));
    check({tag, ".halted"}, int'(h0),    int'(h));
  endtask

  task automatic cmp1(input string tag, input bit v, input logic [7:0] i,
                      input logic [3:0] p, input logic [3:0] a, input bit h);
    check({tag, ".valid"},  int'(v1),    int'(v));
    check({tag, ".instr"},  int'(ins1),  int'(i));
    check({tag, ".pc"},     int'(ipc1),  int'(p));
    check({tag, ".addr"},   int'(addr1), int'(a));
    check({tag, ".halted"}, int'(h1),    int'(h));
  endtask

  // Behavioural model of the stage: a fetch pointer feeding a one-entry buffer.
  logic [3:0] m_pc, m_ipc;
  logic [7:0] m_ins;
  bit         m_v, m_h;

  task automatic model_step(input bit r, input bit y, input bit w, input logic [3:0] t,
                            input bit halt_en);
    if (r) begin
      m_pc = 0; m_ins = 0; m_ipc = 0; m_v = 0; m_h = 0;
    end else if (w) begin
      m_pc = t; m_v = 0; m_h = 0;
    end else if (m_h) begin
      if (m_v && y) m_v = 0;
    end else if (!m_v || y) begin
      m_ins = rom[m_pc];
      m_ipc = m_pc;
      m_v   = 1;
      if (halt_en && m_ins == 8'h00) m_h = 1;
      else m_pc = 4'((int'(m_pc) + 1) % 16);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] init_rom [16];
    init_rom = '{8'hA6, 8'hAF, 8'hB4, 8'hBD, 8'hF8, 8'hCB, 8'hA7, 8'h78,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rom = init_rom;

    rst = 1; rdy = 0; rv = 0; rpc = 0;
    rst1 = 1; rdy1 = 0; rv1 = 0; rpc1 = 0;

    //          rst rdy rv rpc   v  instr  ipc addr h
    vec[0]  = mk(1, 0, 0, 0,    0, 8'h00, 0, 0, 0);  // reset
    vec[1]  = mk(0, 1, 0, 0,    1, 8'hA6, 0, 1, 0);
    vec[2]  = mk(0, 1, 0, 0,    1, 8'hAF, 1, 2, 0);
    vec[3]  = mk(0, 1, 0, 0,    1, 8'hB4, 2, 3, 0);
    vec[4]  = mk(0, 0, 0, 0,    1, 8'hB4, 2, 3, 0);  // stall x3
    vec[5]  = mk(0, 0, 0, 0,    1, 8'hB4, 2, 3, 0);
    vec[6]  = mk(0, 0, 0, 0,    1, 8'hB4, 2, 3, 0);
    vec[7]  = mk(0, 1, 0, 0,    1, 8'hBD, 3, 4, 0);
    vec[8]  = mk(0, 1, 0, 0,    1, 8'hF8, 4, 5, 0);
    vec[9]  = mk(0, 1, 0, 0,    1, 8'hCB, 5, 6, 0);
    vec[10] = mk(0, 1, 0, 0,    1, 8'hA7, 6, 7, 0);
    vec[11] = mk(0, 1, 0, 0,    1, 8'h78, 7, 8, 0);
    vec[12] = mk(0, 1, 0, 0,    1, 8'h00, 8, 8, 1);  // halt word delivered
    vec[13] = mk(0, 1, 0, 0,    0, 8'h00, 8, 8, 1);  // drained, pc parked
    vec[14] = mk(0, 1, 0, 0,    0, 8'h00, 8, 8, 1);
    vec[15] = mk(0, 1, 1, 4,    0, 8'h00, 8, 4, 0);  // redirect out of halt
    vec[16] = mk(0, 1, 0, 0,    1, 8'hF8, 4, 5, 0);
    vec[17] = mk(0, 1, 0, 0,    1, 8'hCB, 5, 6, 0);
    vec[18] = mk(0, 1, 1, 1,    0, 8'hCB, 5, 1, 0);
    vec[19] = mk(0, 1, 0, 0,    1, 8'hAF, 1, 2, 0);
    vec[20] = mk(0, 1, 1, 5,    0, 8'hAF, 1, 5, 0);  // flush despite ready
    vec[21] = mk(0, 1, 0, 0,    1, 8'hCB, 5, 6, 0);
    vec[22] = mk(0, 1, 0, 0,    1, 8'hA7, 6, 7, 0);
    vec[23] = mk(0, 0, 0, 0,    1, 8'hA7, 6, 7, 0);
    vec[24] = mk(1, 0, 0, 0,    0, 8'h00, 0, 0, 0);  // reset mid-stream

    for (int k = 0; k < 25; k++) begin
      rst = vec[k].rst; rdy = vec[k].rdy; rv = vec[k].rv; rpc = vec[k].rpc;
      tick();
      cmp0($sformatf("vec%0d", k), vec[k].v, vec[k].ins, vec[k].ipc, vec[k].addr, vec[k].h);
    end

    // Halt detection off: 00 is an ordinary word and the PC wraps 15 -> 0.
    rst1 = 1; tick();
    cmp1("nh.reset", 0, 8'h00, 0, 0, 0);
    rst1 = 0; rdy1 = 1; rv1 = 1; rpc1 = 15; tick();
    cmp1("nh.redir", 0, 8'h00, 0, 15, 0);
    rv1 = 0; tick();
    cmp1("nh.w15", 1, 8'h00, 15, 0, 0);
    tick();
    cmp1("nh.wrap", 1, 8'hA6, 0, 1, 0);
    rdy1 = 0; tick();
    cmp1("nh.stall", 1, 8'hA6, 0, 1, 0);
    rst1 = 1; tick();
    cmp1("nh.rst", 0, 8'h00, 0, 0, 0);
    rst1 = 0;

    // Randomized traffic against the model, with a few halt words in the ROM.
    for (int a = 0; a < 16; a++)
      rom[a] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    rst = 1; rv = 0; rdy = 0;
    model_step(1, 0, 0, 0, 1);
    tick();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = 4'($urandom_range(0, 15));
      #1;
      if (v0 && rdy && !rst)
        check($sformatf("rnd%0d.xfer_word", c), int'(ins0), int'(rom[ipc0]));
      model_step(rst, rdy, rv, rpc, 1);
      tick();
      cmp0($sformatf("rnd%0d", c), m_v, m_ins, m_ipc, m_pc, m_h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
